// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter for the DE2-115: display reads take absolute priority,
// core reads/writes fill the remaining cycles, one registered bus operation per clock.
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_disp_req,
    input  logic [19:0] i_disp_addr,
    output logic [15:0] o_disp_data,
    output logic        o_disp_valid,

    input  logic        i_core_req,
    input  logic        i_core_we,
    input  logic [19:0] i_core_addr,
    input  logic [15:0] i_core_wdata,
    output logic        o_core_gnt,
    output logic [15:0] o_core_rdata,
    output logic        o_core_rvalid,
    output logic        o_core_starve,

    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DISP_RD = 2'd1;
    localparam logic [1:0] S_CORE_RD = 2'd2;
    localparam logic [1:0] S_CORE_WR = 2'd3;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] wdata;
    logic        dq_oe;
    logic [15:0] wait_cnt;
    logic [15:0] wait_next;

    always_comb begin
        next_state = S_IDLE;
        if (i_disp_req) begin
            next_state = S_DISP_RD;
        end else if (i_core_req) begin
            next_state = i_core_we ? S_CORE_WR : S_CORE_RD;
        end
    end

    // Bus pins are registered from the decision so they change only at the clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_SRAM_ADDR <= '0;
            wdata       <= '0;
            dq_oe       <= 1'b0;
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
        end else begin
            state       <= next_state;
            o_SRAM_LB_N <= 1'b0;
            o_SRAM_UB_N <= 1'b0;
            case (next_state)
                S_DISP_RD: begin
                    o_SRAM_ADDR <= i_disp_addr;
                    o_SRAM_CE_N <= 1'b0;
                    o_SRAM_OE_N <= 1'b0;
                    o_SRAM_WE_N <= 1'b1;
                    dq_oe       <= 1'b0;
                end
                S_CORE_RD: begin
                    o_SRAM_ADDR <= i_core_addr;
                    o_SRAM_CE_N <= 1'b0;
                    o_SRAM_OE_N <= 1'b0;
                    o_SRAM_WE_N <= 1'b1;
                    dq_oe       <= 1'b0;
                end
                S_CORE_WR: begin
                    o_SRAM_ADDR <= i_core_addr;
                    wdata       <= i_core_wdata;
                    o_SRAM_CE_N <= 1'b0;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_WE_N <= 1'b0;
                    dq_oe       <= 1'b1;
                end
                default: begin
                    o_SRAM_CE_N <= 1'b1;
                    o_SRAM_OE_N <= 1'b1;
                    o_SRAM_WE_N <= 1'b1;
                    dq_oe       <= 1'b0;
                end
            endcase
        end
    end

    assign io_SRAM_DQ = dq_oe ? wdata : 'z;
    assign o_core_gnt = (state == S_CORE_RD) || (state == S_CORE_WR);

    // Read data is captured at the edge that ends the read cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_disp_data   <= '0;
            o_disp_valid  <= 1'b0;
            o_core_rdata  <= '0;
            o_core_rvalid <= 1'b0;
        end else begin
            o_disp_valid  <= (state == S_DISP_RD);
            o_core_rvalid <= (state == S_CORE_RD);
            if (state == S_DISP_RD) begin
                o_disp_data <= io_SRAM_DQ;
            end
            if (state == S_CORE_RD) begin
                o_core_rdata <= io_SRAM_DQ;
            end
        end
    end

    always_comb begin
        wait_next = '0;
        if (i_core_req && !o_core_gnt) begin
            wait_next = (wait_cnt != '1) ? wait_cnt + 16'd1 : wait_cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt      <= '0;
            o_core_starve <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            if ({16'd0, wait_next} >= STARVE_LIMIT) begin
                o_core_starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, every cycle
// compared against an operation-level model of the arbiter and the SRAM contents.
module tb_sram_arbiter;

    localparam int unsigned LIMIT = 8;
    localparam logic [15:0] PROBE = 16'h5A3C;
    localparam int K_IDLE = 0;
    localparam int K_DISP = 1;
    localparam int K_CRD  = 2;
    localparam int K_CWR  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [19:0] disp_addr = '0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [19:0] core_addr = '0;
    logic [15:0] core_wdata = '0;

    logic [15:0] o_disp_data;
    logic        o_disp_valid;
    logic        o_core_gnt;
    logic [15:0] o_core_rdata;
    logic        o_core_rvalid;
    logic        o_core_starve;
    logic [19:0] o_SRAM_ADDR;
    wire  [15:0] io_SRAM_DQ;
    logic        o_SRAM_WE_N;
    logic        o_SRAM_CE_N;
    logic        o_SRAM_OE_N;
    logic        o_SRAM_LB_N;
    logic        o_SRAM_UB_N;

    // 64-word SRAM (address aliased on the low 6 bits); a probe pattern sits on the
    // bus whenever neither the SRAM nor a write should drive it, exposing stray drivers.
    logic [15:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always #5 clk = ~clk;

    assign io_SRAM_DQ = o_SRAM_WE_N ?
        ((!o_SRAM_CE_N && !o_SRAM_OE_N) ? mem[o_SRAM_ADDR[5:0]] : PROBE) : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!o_SRAM_CE_N && !o_SRAM_WE_N) begin
            mem[o_SRAM_ADDR[5:0]] <= io_SRAM_DQ;
        end
    end

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_disp_req    (disp_req),
        .i_disp_addr   (disp_addr),
        .o_disp_data   (o_disp_data),
        .o_disp_valid  (o_disp_valid),
        .i_core_req    (core_req),
        .i_core_we     (core_we),
        .i_core_addr   (core_addr),
        .i_core_wdata  (core_wdata),
        .o_core_gnt    (o_core_gnt),
        .o_core_rdata  (o_core_rdata),
        .o_core_rvalid (o_core_rvalid),
        .o_core_starve (o_core_starve),
        .o_SRAM_ADDR   (o_SRAM_ADDR),
        .io_SRAM_DQ    (io_SRAM_DQ),
        .o_SRAM_WE_N   (o_SRAM_WE_N),
        .o_SRAM_CE_N   (o_SRAM_CE_N),
        .o_SRAM_OE_N   (o_SRAM_OE_N),
        .o_SRAM_LB_N   (o_SRAM_LB_N),
        .o_SRAM_UB_N   (o_SRAM_UB_N)
    );

    typedef struct {
        int          kind;
        logic [19:0] addr;
        logic [15:0] wdata;
    } op_t;

    op_t         cur;
    logic [15:0] exp_mem [64];
    bit          m_dv;
    bit          m_rv;
    bit          m_starve;
    bit          m_in_reset;
    logic [15:0] m_dd;
    logic [15:0] m_rd;
    int          m_wait;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        cur.kind   = K_IDLE;
        cur.addr   = '0;
        cur.wdata  = '0;
        m_dv       = 1'b0;
        m_rv       = 1'b0;
        m_dd       = '0;
        m_rd       = '0;
        m_wait     = 0;
        m_starve   = 1'b0;
        m_in_reset = 1'b1;
    endtask

    // One clock edge: retire the operation on the bus, then pick the next one.
    task automatic model_edge();
        m_dv = (cur.kind == K_DISP);
        m_rv = (cur.kind == K_CRD);
        if (m_dv) m_dd = exp_mem[cur.addr[5:0]];
        if (m_rv) m_rd = exp_mem[cur.addr[5:0]];
        if (cur.kind == K_CWR) exp_mem[cur.addr[5:0]] = cur.wdata;
        if (cur.kind == K_CRD || cur.kind == K_CWR || !core_req) m_wait = 0;
        else if (m_wait < 65535) m_wait++;
        if (m_wait >= int'(LIMIT)) m_starve = 1'b1;
        if (disp_req) begin
            cur.kind = K_DISP;
            cur.addr = disp_addr;
        end else if (core_req) begin
            cur.kind  = core_we ? K_CWR : K_CRD;
            cur.addr  = core_addr;
            cur.wdata = core_wdata;
        end else begin
            cur.kind = K_IDLE;
        end
        m_in_reset = 1'b0;
    endtask

    task automatic compare_all();
        bit          rd;
        bit          wr;
        logic [15:0] dq_want;
        rd = (cur.kind == K_DISP) || (cur.kind == K_CRD);
        wr = (cur.kind == K_CWR);
        dq_want = wr ? cur.wdata : (rd ? exp_mem[cur.addr[5:0]] : PROBE);
        chk("ce_n", 32'(o_SRAM_CE_N), 32'(cur.kind == K_IDLE));
        chk("oe_n", 32'(o_SRAM_OE_N), 32'(!rd));
        chk("we_n", 32'(o_SRAM_WE_N), 32'(!wr));
        if (cur.kind != K_IDLE || m_in_reset) begin
            chk("addr", 32'(o_SRAM_ADDR), m_in_reset ? 32'd0 : 32'(cur.addr));
            chk("lb_ub_n", 32'({o_SRAM_LB_N, o_SRAM_UB_N}), m_in_reset ? 32'd3 : 32'd0);
        end
        chk("dq", 32'(io_SRAM_DQ), 32'(dq_want));
        chk("core_gnt", 32'(o_core_gnt), 32'(cur.kind == K_CRD || cur.kind == K_CWR));
        chk("disp_valid", 32'(o_disp_valid), 32'(m_dv));
        chk("disp_data", 32'(o_disp_data), 32'(m_dd));
        chk("core_rvalid", 32'(o_core_rvalid), 32'(m_rv));
        chk("core_rdata", 32'(o_core_rdata), 32'(m_rd));
        chk("core_starve", 32'(o_core_starve), 32'(m_starve));
    endtask

    // Advance one clock; the core agent withdraws its request once it sees the grant.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
        if (o_core_gnt) core_req = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            pre_en     = 1'b1;
            pre_addr   = 6'(i);
            pre_data   = (i == 16) ? 16'hA5A5 : 16'($urandom);
            exp_mem[i] = pre_data;
            @(posedge clk);
            @(negedge clk);
        end
        pre_en = 1'b0;
        compare_all();
        rst = 1'b0;

        // display read
        disp_req  = 1'b1;
        disp_addr = 20'h00010;
        cycle();
        chk("disp_bus_addr", 32'(o_SRAM_ADDR), 32'h00010);
        chk("disp_bus_oe_n", 32'(o_SRAM_OE_N), 32'd0);
        disp_req = 1'b0;
        cycle();
        chk("disp_lat_valid", 32'(o_disp_valid), 32'd1);
        chk("disp_lat_data", 32'(o_disp_data), 32'hA5A5);

        // core write then read
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 20'h0ABCD;
        core_wdata = 16'h1234;
        cycle();
        chk("wr_gnt", 32'(o_core_gnt), 32'd1);
        chk("wr_we_n", 32'(o_SRAM_WE_N), 32'd0);
        chk("wr_dq", 32'(io_SRAM_DQ), 32'h1234);
        cycle();
        core_req = 1'b1;
        core_we  = 1'b0;
        cycle();
        chk("rd_gnt", 32'(o_core_gnt), 32'd1);
        cycle();
        chk("rd_rvalid", 32'(o_core_rvalid), 32'd1);
        chk("rd_rdata", 32'(o_core_rdata), 32'h1234);

        // collision: three display reads go first, then the core
        disp_req  = 1'b1;
        disp_addr = 20'h00005;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 20'h00020;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("collide_gnt", 32'(o_core_gnt), 32'd0);
            chk("collide_oe_n", 32'(o_SRAM_OE_N), 32'd0);
            if (k == 2) disp_req = 1'b0;
        end
        cycle();
        chk("collide_late_gnt", 32'(o_core_gnt), 32'd1);
        cycle();

        // starvation
        rst = 1'b1;
        cycle();
        rst        = 1'b0;
        disp_req   = 1'b1;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 20'h00033;
        core_wdata = 16'hBEEF;
        for (int k = 1; k <= 10; k++) begin
            disp_addr = 20'($urandom);
            cycle();
            chk("starve_flag", 32'(o_core_starve), 32'(k >= 8));
            chk("starve_gnt", 32'(o_core_gnt), 32'd0);
        end
        disp_req = 1'b0;
        cycle();
        chk("starve_gnt_late", 32'(o_core_gnt), 32'd1);
        chk("starve_sticky", 32'(o_core_starve), 32'd1);
        cycle();
        chk("starve_sticky2", 32'(o_core_starve), 32'd1);

        // reset in the middle of a core write, with a read left pending
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 20'h00007;
        core_wdata = 16'hC0DE;
        cycle();
        chk("rstwr_we_n", 32'(o_SRAM_WE_N), 32'd0);
        #2;
        rst       = 1'b1;
        core_req  = 1'b1;
        core_we   = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_we_n", 32'(o_SRAM_WE_N), 32'd1);
        chk("rst_dq", 32'(io_SRAM_DQ), 32'(PROBE));
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        cycle();
        chk("rst_regrant", 32'(o_core_gnt), 32'd1);
        chk("rst_no_rvalid", 32'(o_core_rvalid), 32'd0);
        chk("rst_no_dvalid", 32'(o_disp_valid), 32'd0);
        cycle();

        // alternating display read / core write on a small address window
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) begin
                disp_req  = 1'b1;
                disp_addr = 20'($urandom_range(0, 7));
                core_req  = 1'b0;
            end else begin
                disp_req   = 1'b0;
                core_req   = 1'b1;
                core_we    = 1'b1;
                core_addr  = 20'($urandom_range(0, 7));
                core_wdata = 16'($urandom);
            end
            cycle();
        end
        disp_req = 1'b0;
        core_req = 1'b0;
        cycle();

        // random mixed traffic
        for (int n = 0; n < 3000; n++) begin
            disp_req  = ($urandom_range(0, 99) < 45);
            disp_addr = 20'($urandom);
            if (!core_req && $urandom_range(0, 99) < 50) begin
                core_req   = 1'b1;
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = 20'($urandom);
                core_wdata = 16'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
